// File: rtl/rot_coord_gen_pkg.sv
// Shared definitions for the rotated-coordinate generator.
//   - FSM state encoding
//   - fractional bits, coefficient / accumulator / coordinate widths
//   - signed container types and a coefficient sign-extension helper
package rot_coord_gen_pkg;

    localparam int FRAC_BITS = 10;   // fractional bits of coefficients and coordinates
    localparam int COEF_W    = 12;   // signed Q1.10 rotation coefficient
    localparam int ACC_W     = 24;   // signed Q13.10 accumulator
    localparam int COORD_W   = 11;   // unsigned pixel coordinate

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_RUN      = 2'd2,
        ST_LINE_GAP = 2'd3
    } state_t;

    // Widen a coefficient to accumulator width, keeping its sign.
    function automatic acc_t sext_coef(input coef_t c);
        return acc_t'(c);
    endfunction

endpackage

// File: rtl/rot_setup_mult.sv
// Pair of signed 12x12 multipliers with registered 24-bit products.
// Used while the row-start accumulators are being set up.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   a0,b0 / a1,b1 signed operand pairs
//   p0 / p1       registered products a0*b0 and a1*b1
module rot_setup_mult
    import rot_coord_gen_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  coef_t a0,
    input  coef_t b0,
    input  coef_t a1,
    input  coef_t b1,
    output acc_t  p0,
    output acc_t  p1
);

    // Product registers; operands widened first so the full product is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0 <= {ACC_W{1'b0}};
            p1 <= {ACC_W{1'b0}};
        end else begin
            p0 <= acc_t'(a0) * acc_t'(b0);
            p1 <= acc_t'(a1) * acc_t'(b1);
        end
    end

endmodule

// File: rtl/rot_coord_gen.sv
// Rotated source-coordinate generator for a bilinear rotation engine.
// For every output pixel (x,y) of an H_ACT x V_ACT frame it produces the
// integer top-left neighbour and fractional weights of the rotated source
// point, plus an inside flag, under a valid/ready handshake.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-low reset
//   i_start             frame-start pulse (taken only when idle)
//   iv_cos, iv_sin      signed Q1.10 coefficients, latched on start
//   iv_cx, iv_cy        rotation centre, latched on start
//   i_ready             downstream accepts the current output
//   o_valid, o_hsyn     output valid (identical signals)
//   ov_x0, ov_y0        integer neighbour coordinate (0 when outside)
//   ov_fx, ov_fy        fractional weights 0..1023 (0 when outside)
//   o_inside            all four neighbours inside the source image
//   o_frame_done        one-cycle pulse after the last pixel is accepted
module rot_coord_gen
    import rot_coord_gen_pkg::*;
#(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int FRAC  = FRAC_BITS
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  coef_t              iv_cos,
    input  coef_t              iv_sin,
    input  logic [COORD_W-1:0] iv_cx,
    input  logic [COORD_W-1:0] iv_cy,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [COORD_W-1:0] ov_x0,
    output logic [COORD_W-1:0] ov_y0,
    output logic [COORD_W-1:0] ov_fx,
    output logic [COORD_W-1:0] ov_fy,
    output logic               o_inside,
    output logic               o_hsyn,
    output logic               o_frame_done
);

    localparam int INT_W = ACC_W - FRAC;
    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(H_ACT - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(V_ACT - 1);
    localparam logic [COORD_W-1:0] CNT_ONE = COORD_W'(1);
    localparam logic signed [INT_W-1:0] X_MAX = INT_W'(H_ACT - 2);
    localparam logic signed [INT_W-1:0] Y_MAX = INT_W'(V_ACT - 2);

    state_t             state_r, state_nxt_s;
    logic               setup_cnt_r;
    coef_t              cos_r, sin_r;
    logic [COORD_W-1:0] cx_r, cy_r;
    acc_t               xr_r, yr_r, xs_r, ys_r;
    logic [COORD_W-1:0] x_cnt_r, y_cnt_r;

    coef_t              ma0_s, mb0_s, ma1_s, mb1_s;
    acc_t               prod0_s, prod1_s;
    acc_t               cx_fix_s, cy_fix_s, xr_init_s, yr_init_s;
    logic signed [INT_W-1:0] ix_s, iy_s;
    logic               inside_s;
    logic               accept_s, gen_s, eol_s, eof_s;

    // Operand select: the first product pair is issued straight from the
    // inputs in the start cycle, so both pairs are ready by the end of SETUP.
    always_comb begin
        if (state_r == ST_IDLE) begin
            ma0_s = iv_cos;  mb0_s = {1'b0, iv_cx};
            ma1_s = iv_sin;  mb1_s = {1'b0, iv_cy};
        end else begin
            ma0_s = sin_r;   mb0_s = {1'b0, cx_r};
            ma1_s = cos_r;   mb1_s = {1'b0, cy_r};
        end
    end

    rot_setup_mult u_mult (
        .clk   (i_clk),
        .rst_n (i_reset),
        .a0    (ma0_s),
        .b0    (mb0_s),
        .a1    (ma1_s),
        .b1    (mb1_s),
        .p0    (prod0_s),
        .p1    (prod1_s)
    );

    // Row-start values: SETUP cycle 0 sees cos*cx, sin*cy; cycle 1 sees sin*cx, cos*cy.
    assign cx_fix_s  = {{(ACC_W-COORD_W-FRAC){1'b0}}, cx_r, {FRAC{1'b0}}};
    assign cy_fix_s  = {{(ACC_W-COORD_W-FRAC){1'b0}}, cy_r, {FRAC{1'b0}}};
    assign xr_init_s = cx_fix_s - prod0_s - prod1_s;
    assign yr_init_s = cy_fix_s + prod0_s - prod1_s;

    // Integer part (floor) of the current source point and inside test.
    assign ix_s     = xs_r[ACC_W-1:FRAC];
    assign iy_s     = ys_r[ACC_W-1:FRAC];
    assign inside_s = (ix_s >= $signed({INT_W{1'b0}})) && (ix_s <= X_MAX) &&
                      (iy_s >= $signed({INT_W{1'b0}})) && (iy_s <= Y_MAX);

    assign accept_s = o_valid & i_ready;
    assign o_hsyn   = o_valid;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and datapath strobes. gen_s loads a new pixel into the
    // output register (first pixel of a line, or after an accept).
    always_comb begin
        state_nxt_s = state_r;
        gen_s       = 1'b0;
        eol_s       = 1'b0;
        eof_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start) state_nxt_s = ST_SETUP;
                else         state_nxt_s = ST_IDLE;
            end
            ST_SETUP: begin
                if (setup_cnt_r) state_nxt_s = ST_RUN;
                else             state_nxt_s = ST_SETUP;
            end
            ST_RUN: begin
                if (!o_valid) begin
                    gen_s = 1'b1;
                end else if (accept_s) begin
                    if (x_cnt_r == X_LAST) begin
                        if (y_cnt_r == Y_LAST) begin
                            eof_s       = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            eol_s       = 1'b1;
                            state_nxt_s = ST_LINE_GAP;
                        end
                    end else begin
                        gen_s = 1'b1;
                    end
                end else begin
                    gen_s = 1'b0;  // stalled: everything holds
                end
            end
            ST_LINE_GAP: state_nxt_s = ST_RUN;
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // Coefficient latch, accumulators, pixel counters and output registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            setup_cnt_r  <= 1'b0;
            cos_r        <= {COEF_W{1'b0}};
            sin_r        <= {COEF_W{1'b0}};
            cx_r         <= {COORD_W{1'b0}};
            cy_r         <= {COORD_W{1'b0}};
            xr_r         <= {ACC_W{1'b0}};
            yr_r         <= {ACC_W{1'b0}};
            xs_r         <= {ACC_W{1'b0}};
            ys_r         <= {ACC_W{1'b0}};
            x_cnt_r      <= {COORD_W{1'b0}};
            y_cnt_r      <= {COORD_W{1'b0}};
            o_valid      <= 1'b0;
            ov_x0        <= {COORD_W{1'b0}};
            ov_y0        <= {COORD_W{1'b0}};
            ov_fx        <= {COORD_W{1'b0}};
            ov_fy        <= {COORD_W{1'b0}};
            o_inside     <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= eof_s;
            if (state_r == ST_IDLE && i_start) begin
                cos_r       <= iv_cos;
                sin_r       <= iv_sin;
                cx_r        <= iv_cx;
                cy_r        <= iv_cy;
                setup_cnt_r <= 1'b0;
            end else if (state_r == ST_SETUP) begin
                setup_cnt_r <= ~setup_cnt_r;
                if (!setup_cnt_r) begin
                    xr_r <= xr_init_s;
                end else begin
                    yr_r    <= yr_init_s;
                    xs_r    <= xr_r;
                    ys_r    <= yr_init_s;
                    x_cnt_r <= {COORD_W{1'b0}};
                    y_cnt_r <= {COORD_W{1'b0}};
                end
            end else if (gen_s) begin
                o_valid  <= 1'b1;
                o_inside <= inside_s;
                ov_x0    <= inside_s ? ix_s[COORD_W-1:0] : {COORD_W{1'b0}};
                ov_y0    <= inside_s ? iy_s[COORD_W-1:0] : {COORD_W{1'b0}};
                ov_fx    <= inside_s ? {{(COORD_W-FRAC){1'b0}}, xs_r[FRAC-1:0]} : {COORD_W{1'b0}};
                ov_fy    <= inside_s ? {{(COORD_W-FRAC){1'b0}}, ys_r[FRAC-1:0]} : {COORD_W{1'b0}};
                xs_r     <= xs_r + sext_coef(cos_r);
                ys_r     <= ys_r - sext_coef(sin_r);
                // The first pixel of a line is loaded with o_valid low and keeps x=0.
                if (o_valid) x_cnt_r <= x_cnt_r + CNT_ONE;
            end else if (eol_s) begin
                o_valid <= 1'b0;
                xr_r    <= xr_r + sext_coef(sin_r);
                yr_r    <= yr_r + sext_coef(cos_r);
                xs_r    <= xr_r + sext_coef(sin_r);
                ys_r    <= yr_r + sext_coef(cos_r);
                x_cnt_r <= {COORD_W{1'b0}};
                y_cnt_r <= y_cnt_r + CNT_ONE;
            end else if (eof_s) begin
                o_valid <= 1'b0;
                x_cnt_r <= {COORD_W{1'b0}};
                y_cnt_r <= {COORD_W{1'b0}};
            end else begin
                o_valid <= o_valid;
            end
        end
    end

endmodule

// File: doc/rot_coord_gen.md
ROT_COORD_GEN -- requirements
Module: rot_coord_gen

Interface
REQ-001 Parameters: H_ACT, default 640, active pixels per line; V_ACT, default 480, active lines per frame; FRAC, default 10, fractional bits of coordinates and coefficients.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 i_clk  in  1  system clock, all state on rising edge.
REQ-004 i_reset  in  1  asynchronous active-low reset.
REQ-005 i_start  in  1  one-cycle frame-start pulse, accepted only in IDLE.
REQ-006 iv_cos, iv_sin  in  12 each  signed Q1.10 rotation coefficients, range -1024..1024.
REQ-007 iv_cx, iv_cy  in  11 each  unsigned rotation centre in pixels.
REQ-008 i_ready  in  1  downstream accepts current output.
REQ-009 o_valid  out  1  output coordinate set valid.
REQ-010 ov_x0, ov_y0  out  11 each  integer top-left neighbour coordinate of source point.
REQ-011 ov_fx, ov_fy  out  11 each  fractional weights, 0..1023, to the bilinear output stage.
REQ-012 o_inside  out  1  all four neighbours lie inside the source image.
REQ-013 o_hsyn  out  1  high while output pixels of a line are presented.
REQ-014 o_frame_done  out  1  one-cycle pulse after last pixel of frame is accepted.

Function
REQ-015 FSM states IDLE, SETUP, RUN, LINE_GAP; IDLE->SETUP on i_start; SETUP->RUN after 2 cycles; RUN->LINE_GAP on acceptance of pixel x=H_ACT-1 when y<V_ACT-1; LINE_GAP->RUN after 1 cycle; RUN->IDLE on acceptance of pixel (H_ACT-1,V_ACT-1) with o_frame_done pulsed.
REQ-016 iv_cos, iv_sin, iv_cx, iv_cy are latched on i_start; later input changes do not affect the running frame.
REQ-017 i_start outside IDLE is ignored.
REQ-018 SETUP computes row-start accumulators xr = cx<<FRAC - cos*cx - sin*cy, yr = cy<<FRAC + sin*cx - cos*cy, one signed multiply pair per cycle.
REQ-019 Accumulators are signed 24-bit (Q13.10); no saturation, intermediates never exceed that range for legal inputs.
REQ-020 Per accepted pixel in a line: xs += cos, ys -= sin; per line: xr += sin, yr += cos, and xs,ys reload from xr,yr.
REQ-021 Output is registered: values for pixel (x,y) appear one cycle after that pixel is generated in RUN.
REQ-022 Handshake: a pixel is accepted when o_valid and i_ready are both high; while o_valid=1 and i_ready=0 all outputs, counters and accumulators hold.
REQ-023 ov_x0 = xs>>FRAC, ov_fx = xs[FRAC-1:0]; likewise y.
REQ-024 o_inside = 1 only when 0 <= xs>>FRAC <= H_ACT-2 and 0 <= ys>>FRAC <= V_ACT-2; when 0, ov_x0, ov_y0, ov_fx, ov_fy are forced to 0.
REQ-025 o_valid and o_hsyn are 0 in IDLE, SETUP and LINE_GAP; o_hsyn equals o_valid.

Reset
REQ-026 Reset asserted at any time returns FSM to IDLE within the same cycle, discarding any frame in progress.
REQ-027 Reset values: all outputs 0, counters 0, accumulators 0, latched coefficients 0.

Structure
REQ-028 Shared package holds state encoding, FRAC, coefficient width (12), accumulator width (24), coordinate width (11).
REQ-029 One sub-module natural: rot_setup_mult, signed 12x12 registered multiplier used in SETUP.

Verification
REQ-030 Identity: cos=1024, sin=0, cx=320, cy=240, i_ready=1 -> pixel (0,0): x0=0,y0=0,fx=0,fy=0,inside=1; pixel (639,0): inside=0, outputs 0.
REQ-031 90 deg: cos=0, sin=1024, cx=320, cy=240 -> pixel (0,0): inside=0; pixel (320,240): x0=320, y0=240, inside=1.
REQ-032 Fraction: cos=724, sin=0, cx=cy=0 -> pixel (1,0): x0=0, fx=724; pixel (2,0): x0=1, fx=424.
REQ-033 Stall: i_ready low 5 cycles at pixel (10,3) -> outputs hold 5 cycles, next pixel (11,3), no pixel skipped or duplicated; frame delivers exactly 307200 accepted pixels, o_frame_done once.
REQ-034 Reset at pixel (100,50) -> all outputs 0 next cycle; subsequent i_start restarts at pixel (0,0).
REQ-035 i_start pulsed mid-frame and coefficient change mid-frame -> no effect on running frame outputs.
